// File: rtl/compound_sink_accumulator_pkg.sv
// Local types for the compound sink accumulator.
package compound_sink_accumulator_types;

    localparam int unsigned COUNT_W = 8;

    typedef enum logic [0:0] {
        ST_READ = 1'b0,
        ST_EMIT = 1'b1
    } States;

endpackage

// File: rtl/top_level_types_pkg.sv
// Shared stream types used across the codebase.
// CompoundType is the payload carried on the b_out blocking stream.
package top_level_types;

    localparam int unsigned X_W = 32;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } mode_t;

    typedef struct packed {
        mode_t                 mode;
        logic signed [X_W-1:0] x;
        logic                  y;
    } CompoundType;

endpackage

// File: rtl/compound_sink_accumulator.sv
// Sums x of read-mode words and flushes the total on a write word or on a full frame.
// The flushed sum is offered on a blocking port; input stalls until it is taken.
module compound_sink_accumulator
    import top_level_types::*;
    import compound_sink_accumulator_types::*;
#(
    parameter int unsigned MAX_COUNT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  CompoundType              c_in,
    input  logic                     c_in_sync,
    output logic                     c_in_notify,
    output logic signed [X_W-1:0]    sum_out,
    input  logic                     sum_out_sync,
    output logic                     sum_out_notify,
    output logic [COUNT_W-1:0]       count_out
);

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_COUNT);

    States                  state_q,       state_d;
    logic signed [X_W-1:0]  acc_q,         acc_d;
    logic [COUNT_W-1:0]     count_q,       count_d;
    logic [COUNT_W-1:0]     count_out_q,   count_out_d;
    logic signed [X_W-1:0]  sum_q,         sum_d;
    logic                   in_rdy_q,      in_rdy_d;
    logic                   sum_vld_q,     sum_vld_d;

    logic                   in_xfer;
    logic signed [X_W-1:0]  acc_sum;
    logic [COUNT_W-1:0]     count_inc;

    assign in_xfer   = c_in_sync & in_rdy_q;
    assign acc_sum   = acc_q + c_in.x;
    assign count_inc = count_q + COUNT_W'(1);

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        count_out_d = count_out_q;
        sum_d       = sum_q;
        in_rdy_d    = in_rdy_q;
        sum_vld_d   = sum_vld_q;

        case (state_q)
            ST_READ: begin
                if (in_xfer) begin
                    if (c_in.mode == write) begin
                        sum_d     = acc_q;
                        state_d   = ST_EMIT;
                        in_rdy_d  = 1'b0;
                        sum_vld_d = 1'b1;
                        // y=0 keeps the frame open across the flush
                        if (c_in.y) begin
                            acc_d       = '0;
                            count_d     = '0;
                            count_out_d = '0;
                        end
                    end else if (count_inc == MAX_CNT) begin
                        sum_d       = acc_sum;
                        acc_d       = '0;
                        count_d     = '0;
                        count_out_d = MAX_CNT;
                        state_d     = ST_EMIT;
                        in_rdy_d    = 1'b0;
                        sum_vld_d   = 1'b1;
                    end else begin
                        acc_d       = acc_sum;
                        count_d     = count_inc;
                        count_out_d = count_inc;
                    end
                end
            end
            ST_EMIT: begin
                if (sum_out_sync) begin
                    state_d   = ST_READ;
                    in_rdy_d  = 1'b1;
                    sum_vld_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_READ;
                in_rdy_d  = 1'b1;
                sum_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_READ;
            acc_q       <= '0;
            count_q     <= '0;
            count_out_q <= '0;
            sum_q       <= '0;
            in_rdy_q    <= 1'b1;
            sum_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            count_out_q <= count_out_d;
            sum_q       <= sum_d;
            in_rdy_q    <= in_rdy_d;
            sum_vld_q   <= sum_vld_d;
        end
    end

    assign c_in_notify    = in_rdy_q;
    assign sum_out_notify = sum_vld_q;
    assign sum_out        = sum_q;
    assign count_out      = count_out_q;

endmodule

// File: tb/tb_compound_sink_accumulator.sv
// Scoreboard bench: driver feeds words and pushes expected flushes,
// a negedge monitor pops and compares on every sum_out transfer.
module tb_compound_sink_accumulator;
    import top_level_types::*;

    localparam int unsigned MAX = 4;

    logic               clk = 1'b0;
    logic               rst;
    CompoundType        c_in;
    logic               c_in_sync;
    logic               c_in_notify;
    logic signed [31:0] sum_out;
    logic               sum_out_sync;
    logic               sum_out_notify;
    logic [7:0]         count_out;

    compound_sink_accumulator #(.MAX_COUNT(MAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .c_in           (c_in),
        .c_in_sync      (c_in_sync),
        .c_in_notify    (c_in_notify),
        .sum_out        (sum_out),
        .sum_out_sync   (sum_out_sync),
        .sum_out_notify (sum_out_notify),
        .count_out      (count_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: frame sum, frame length, mirrored count, expected flushes
    logic signed [31:0] exp_q[$];
    logic signed [31:0] acc_m;
    int                 cnt_m;
    int                 cout_m;
    int                 rdy_mode;   // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input CompoundType w, output bit flush);
        flush = 1'b0;
        if (w.mode == write) begin
            exp_q.push_back(acc_m);
            flush = 1'b1;
            if (w.y) begin
                acc_m  = 0;
                cnt_m  = 0;
                cout_m = 0;
            end
        end else begin
            acc_m = acc_m + w.x;
            cnt_m = cnt_m + 1;
            if (cnt_m == int'(MAX)) begin
                exp_q.push_back(acc_m);
                acc_m  = 0;
                cnt_m  = 0;
                cout_m = MAX;
                flush  = 1'b1;
            end else begin
                cout_m = cnt_m;
            end
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the transfer
    task automatic send(input mode_t m, input logic signed [31:0] x, input logic y);
        CompoundType w;
        bit fl;
        int n;
        n = 0;
        w.mode = m;
        w.x    = x;
        w.y    = y;
        c_in      = w;
        c_in_sync = 1'b1;
        while (c_in_notify !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: c_in_notify=%b after %0d cycles, required 1", c_in_notify, n);
            return;
        end
        @(posedge clk);
        model(w, fl);
        @(negedge clk);
        chk("count_out", 32'(count_out), 32'(cout_m));
        chk("flush_notify", 32'(sum_out_notify), 32'(fl));
        chk("c_in_notify_after", 32'(c_in_notify), 32'(!fl));
    endtask

    task automatic idle(input int n);
        c_in_sync = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pick downstream readiness, then check whatever sum_out offers this cycle
    always @(negedge clk) begin
        if (rdy_mode == 1)      sum_out_sync = 1'b1;
        else if (rdy_mode == 2) sum_out_sync = 1'b0;
        else                    sum_out_sync = ($urandom_range(0, 99) < 70);
        if (!rst && sum_out_notify === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sum_out_unexpected: got %h with no flush expected", sum_out);
            end else if (sum_out_sync) begin
                chk("sum_out", sum_out, exp_q.pop_front());
            end else begin
                chk("sum_out_hold", sum_out, exp_q[0]);
            end
        end
    end

    initial begin
        logic signed [31:0] rx;
        int r;
        int n;
        rst       = 1'b1;
        c_in      = '0;
        c_in_sync = 1'b0;
        acc_m     = 0;
        cnt_m     = 0;
        cout_m    = 0;
        rdy_mode  = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_c_in_notify", 32'(c_in_notify), 32'd1);
        chk("rst_sum_notify", 32'(sum_out_notify), 32'd0);
        chk("rst_sum_out", sum_out, 32'd0);
        chk("rst_count_out", 32'(count_out), 32'd0);

        // Basic frame closed by write y=1
        send(read, 5, 1'b0);
        send(read, 7, 1'b1);
        send(read, -2, 1'b0);
        send(write, 32'd99, 1'b1);
        idle(2);

        // Write y=0 keeps accumulating
        send(read, 3, 1'b0);
        send(read, 4, 1'b0);
        send(write, 0, 1'b0);
        send(read, 1, 1'b0);
        send(write, 0, 1'b1);
        idle(2);

        // Forced flush at MAX words
        repeat (4) send(read, 1, 1'b0);
        send(read, 2, 1'b0);
        send(write, 0, 1'b1);
        idle(2);

        // Downstream stall with upstream pushing
        rdy_mode = 2;
        send(read, 11, 1'b0);
        send(write, 0, 1'b1);
        c_in.mode = read;
        c_in.x    = 9;
        c_in.y    = 1'b0;
        c_in_sync = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("stall_c_in_notify", 32'(c_in_notify), 32'd0);
            chk("stall_count_out", 32'(count_out), 32'(cout_m));
        end
        @(posedge clk);
        rdy_mode = 1;
        @(negedge clk);
        chk("release_c_in_notify_lo", 32'(c_in_notify), 32'd0);
        @(negedge clk);
        chk("release_c_in_notify_hi", 32'(c_in_notify), 32'd1);
        chk("release_sum_notify", 32'(sum_out_notify), 32'd0);
        chk("release_single_xfer", 32'(exp_q.size()), 32'd0);
        send(read, 9, 1'b0);
        send(write, 0, 1'b1);
        idle(2);

        // Two's complement wrap
        send(read, 32'h7FFF_FFFF, 1'b0);
        send(read, 1, 1'b0);
        send(write, 0, 1'b1);
        idle(2);

        // Reset aborts a pending flush
        rdy_mode = 2;
        send(read, 6, 1'b0);
        send(write, 0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_sum_notify", 32'(sum_out_notify), 32'd0);
        chk("mid_rst_c_in_notify", 32'(c_in_notify), 32'd1);
        chk("mid_rst_sum_out", sum_out, 32'd0);
        chk("mid_rst_count_out", 32'(count_out), 32'd0);
        exp_q.delete();
        acc_m     = 0;
        cnt_m     = 0;
        cout_m    = 0;
        c_in_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        rdy_mode = 1;
        @(negedge clk);
        send(write, 0, 1'b1);
        idle(3);

        // Randomized traffic with random downstream readiness
        rdy_mode = 0;
        repeat (400) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0) rx = $urandom;
            else                           rx = $signed($urandom_range(0, 200)) - 100;
            if (r < 8)       idle($urandom_range(1, 3));
            else if (r < 20) send(write, rx, 1'($urandom_range(0, 1)));
            else             send(read, rx, 1'($urandom_range(0, 1)));
        end
        idle(1);
        rdy_mode = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
